inv_sub_bytes_seq: RTL and testbench

Multi-cycle AES InvSubBytes stage for the decryption datapath. It sits directly downstream of the inverse-ShiftRows stage and consumes its 128-bit state. It substitutes BYTES_PER_CYCLE bytes per clock through shared inverse S-box instances, so area can be traded for latency. A valid/ready handshake on both sides lets the round controller stall it.

---
 rtl/inv_sub_bytes_seq.sv | 130 +++++++++++++
 tb/tb_inv_sub_bytes_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sub_bytes_seq.sv
// inv_sub_bytes_seq: multi-cycle AES InvSubBytes stage.
// Substitutes BYTES_PER_CYCLE bytes of the 128-bit state per clock through
// shared inverse S-box lanes, with valid/ready handshakes on both sides.

// One inverse S-box lane: inverse affine transform, then GF(2^8) inverse.
module inv_sbox_lane (
   input  logic [7:0] a,
   output logic [7:0] y
);
   // GF(2^8) multiply modulo x^8+x^4+x^3+x+1 (0x11B)
   function automatic logic [7:0] gf_mul(input logic [7:0] m, input logic [7:0] n);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = m;
      for (int i = 0; i < 8; i++) begin
         if (n[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
      end
      return p;
   endfunction

   // x^254 is the multiplicative inverse; 0 maps to 0 naturally
   function automatic logic [7:0] gf_inv(input logic [7:0] v);
      logic [7:0] r;
      logic [7:0] b;
      logic [7:0] e;
      r = 8'h01;
      b = v;
      e = 8'hFE;
      for (int i = 0; i < 8; i++) begin
         if (e[i]) r = gf_mul(r, b);
         b = gf_mul(b, b);
      end
      return r;
   endfunction

   logic [7:0] aff;

   // inverse affine: rotl1 ^ rotl3 ^ rotl6 ^ 0x05, then field inverse
   always_comb begin
      aff = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
      y   = gf_inv(aff);
   end
endmodule

module inv_sub_bytes_seq #(
   parameter int BYTES_PER_CYCLE = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] data_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] data_out
);
   localparam int NCH = 16 / BYTES_PER_CYCLE;
   localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int CHW = 8 * BYTES_PER_CYCLE;

   if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
         BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_param
      $error("inv_sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
   end

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  idx_q, idx_d;
   logic [127:0]   work_q, work_d;
   logic [BYTES_PER_CYCLE-1:0][7:0] lane_in, lane_out;

   // current chunk; byte 0 sits at the MSB end, so chunk idx starts at 127-idx*CHW
   always_comb lane_in = work_q[127 - int'(idx_q) * CHW -: CHW];

   for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_lane
      inv_sbox_lane u_lane (.a(lane_in[g]), .y(lane_out[g]));
   end

   // next-state: clear overrides everything, chunk written back while BUSY
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      work_d  = work_q;
      if (clear) begin
         state_d = IDLE;
         idx_d   = '0;
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               work_d  = data_in;
               idx_d   = '0;
               state_d = BUSY;
            end
            BUSY: begin
               work_d[127 - int'(idx_q) * CHW -: CHW] = lane_out;
               if (idx_q == CW'(NCH - 1)) begin
                  idx_d   = '0;
                  state_d = DONE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // state, counter and working register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         work_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         work_q  <= work_d;
      end
   end

   // handshakes decode registered state only: no input-to-output comb paths
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign data_out  = work_q;
endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Bench for inv_sub_bytes_seq: constant vectors, latency across widths,
// stall / clear / async reset corners and a random stream vs a table model.
module tb_inv_sub_bytes_seq;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         clear = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [127:0] data_in = '0;
   logic         in_ready, out_valid;
   logic [127:0] data_out;
   logic         aux_ready = 1'b1;
   logic [3:0]   aux_ir, aux_ov;
   logic [127:0] aux_do [4];

   int checks = 0;
   int errors = 0;
   logic [7:0] inv_tbl [256];

   always #5 clk = ~clk;

   inv_sub_bytes_seq #(.BYTES_PER_CYCLE(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
      .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out));
   inv_sub_bytes_seq #(.BYTES_PER_CYCLE(1)) u_b1 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(aux_ir[0]),
      .data_in(data_in), .out_valid(aux_ov[0]), .out_ready(aux_ready), .data_out(aux_do[0]));
   inv_sub_bytes_seq #(.BYTES_PER_CYCLE(2)) u_b2 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(aux_ir[1]),
      .data_in(data_in), .out_valid(aux_ov[1]), .out_ready(aux_ready), .data_out(aux_do[1]));
   inv_sub_bytes_seq #(.BYTES_PER_CYCLE(8)) u_b8 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(aux_ir[2]),
      .data_in(data_in), .out_valid(aux_ov[2]), .out_ready(aux_ready), .data_out(aux_do[2]));
   inv_sub_bytes_seq #(.BYTES_PER_CYCLE(16)) u_b16 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(aux_ir[3]),
      .data_in(data_in), .out_valid(aux_ov[3]), .out_ready(aux_ready), .data_out(aux_do[3]));

   // reference model: forward S-box from brute-force inverse + FIPS affine, then inverted
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h11B << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
      logic [15:0] t = {v, v} << n;
      return t[15:8];
   endfunction

   task automatic build_tables();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv = 8'h00;
         logic [7:0] s;
         if (x != 0)
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
         inv_tbl[s] = 8'(x);
      end
   endtask

   function automatic logic [127:0] model_state(input logic [127:0] d);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = inv_tbl[d[127 - 8*i -: 8]];
      return r;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk128(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // present one state from IDLE, wait (bounded) for out_valid, then handshake
   task automatic xfer(input logic [127:0] d, output logic [127:0] q, output int lat);
      data_in = d; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0; data_in = rand128();
      lat = -1; q = '0;
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (out_valid) begin lat = c; q = data_out; break; end
      end
      if (lat > 0) begin out_ready = 1'b1; tick(); out_ready = 1'b0; end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
      tick();
   endtask

   typedef struct {
      logic [127:0] din;
      logic [127:0] exp;
   } vec_t;

   initial begin
      vec_t vecs[5];
      logic [127:0] q, v;
      int lat;

      build_tables();
      vecs[0] = '{{16{8'h63}}, 128'h0};
      vecs[1] = '{{4{32'h637C0016}}, {4{32'h000152FF}}};
      vecs[2] = '{{16{8'hED}}, {16{8'h53}}};
      vecs[3] = '{{16{8'h00}}, {16{8'h52}}};
      v = rand128();
      vecs[4] = '{v, model_state(v)};

      // reset values while rst_n is held low
      #12;
      chk_int("reset in_ready", int'(in_ready), 1);
      chk_int("reset out_valid", int'(out_valid), 0);
      chk128("reset data_out", data_out, '0);
      rst_n = 1'b1;
      tick();

      // table vectors on the default width
      for (int i = 0; i < 5; i++) begin
         xfer(vecs[i].din, q, lat);
         chk_int($sformatf("vec%0d latency", i), lat, 4);
         chk128($sformatf("vec%0d data", i), q, vecs[i].exp);
         chk_int($sformatf("vec%0d in_ready after", i), int'(in_ready), 1);
      end

      // latency and data for every width from one shared accept edge
      begin
         int lats[5];
         logic [127:0] got[5];
         int exp_lat[5];
         exp_lat = '{16, 8, 2, 1, 4};
         lats = '{-1, -1, -1, -1, -1};
         do_reset();
         data_in = {4{32'h637C0016}}; in_valid = 1'b1; out_ready = 1'b0;
         tick();
         in_valid = 1'b0;
         for (int c = 1; c <= 24; c++) begin
            tick();
            for (int k = 0; k < 4; k++)
               if (aux_ov[k] && lats[k] < 0) begin lats[k] = c; got[k] = aux_do[k]; end
            if (out_valid && lats[4] < 0) begin lats[4] = c; got[4] = data_out; end
         end
         for (int k = 0; k < 5; k++) begin
            chk_int($sformatf("width%0d latency", k), lats[k], exp_lat[k]);
            chk128($sformatf("width%0d data", k), got[k], {4{32'h000152FF}});
         end
         out_ready = 1'b1; tick(); out_ready = 1'b0;
      end

      // downstream stall with in_valid and data_in churning
      begin
         int bad = 0;
         int waited = 0;
         v = rand128();
         data_in = v; in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         while (!out_valid && waited < 20) begin tick(); waited++; end
         chk_int("stall out_valid rose", int'(out_valid), 1);
         for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1; data_in = rand128();
            tick();
            if (!out_valid || in_ready || data_out !== model_state(v)) bad++;
         end
         chk_int("stall hold cycles bad", bad, 0);
         chk128("stall data", data_out, model_state(v));
         in_valid = 1'b0; out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
         chk_int("stall release in_ready", int'(in_ready), 1);
         chk_int("stall release out_valid", int'(out_valid), 0);
      end

      // clear in the second BUSY cycle discards the state
      begin
         int seen = 0;
         data_in = {4{32'h637C0016}}; in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         tick();
         clear = 1'b1;
         tick();
         clear = 1'b0;
         chk_int("clear in_ready", int'(in_ready), 1);
         for (int c = 0; c < 8; c++) begin tick(); if (out_valid) seen++; end
         chk_int("clear out_valid seen", seen, 0);
         xfer({16{8'hED}}, q, lat);
         chk_int("post-clear latency", lat, 4);
         chk128("post-clear data", q, {16{8'h53}});
      end

      // clear together with in_valid in IDLE: nothing accepted
      begin
         int seen = 0;
         data_in = {16{8'h63}}; in_valid = 1'b1; clear = 1'b1;
         tick();
         in_valid = 1'b0; clear = 1'b0;
         chk_int("clear+valid in_ready", int'(in_ready), 1);
         for (int c = 0; c < 8; c++) begin tick(); if (out_valid) seen++; end
         chk_int("clear+valid out_valid seen", seen, 0);
      end

      // asynchronous reset mid-BUSY, observed before any clock edge
      data_in = {4{32'h637C0016}}; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk_int("async rst in_ready", int'(in_ready), 1);
      chk_int("async rst out_valid", int'(out_valid), 0);
      chk128("async rst data_out", data_out, '0);
      #1;
      rst_n = 1'b1;
      tick();
      xfer({16{8'hED}}, q, lat);
      chk_int("post-reset latency", lat, 4);
      chk128("post-reset data", q, {16{8'h53}});

      // random stream with random handshakes against the table model
      begin
         logic [127:0] exp_q[$];
         logic [127:0] pend;
         int sent = 0;
         int rcvd = 0;
         pend = rand128();
         for (int cyc = 0; cyc < 40000 && rcvd < 1000; cyc++) begin
            in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            data_in   = in_valid ? pend : rand128();
            out_ready = ($urandom_range(0, 2) != 0);
            if (in_valid && in_ready) begin
               exp_q.push_back(model_state(pend));
               sent++;
               pend = rand128();
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL rand extra output: got %h expected none", data_out);
               end else begin
                  chk128($sformatf("rand data %0d", rcvd), data_out, exp_q.pop_front());
               end
               rcvd++;
            end
            tick();
         end
         in_valid = 1'b0; out_ready = 1'b0;
         chk_int("rand sent", sent, 1000);
         chk_int("rand received", rcvd, 1000);
         chk_int("rand leftover", exp_q.size(), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
